// File: rtl/ide_ctrl_pkg.sv
// Shared types and default timing for the IDE device-side control signal generator.
//   - iordy_state_e / dmarq_state_e : FSM state encodings
//   - *Dflt localparams             : default timing in ATA PIO-mode-4 clk cycles
package ide_ctrl_pkg;

   typedef enum logic [1:0] {
      IordyIdle,
      IordyWait,
      IordyRelease
   } iordy_state_e;

   typedef enum logic [1:0] {
      DmarqIdle,
      DmarqReq,
      DmarqHold
   } dmarq_state_e;

   localparam int unsigned IordyTimeoutDflt = 1250;
   localparam int unsigned IordyReleaseDflt = 2;
   localparam int unsigned DmaBurstDflt     = 16;
   localparam int unsigned DmaHoldoffDflt   = 4;

endpackage

// File: rtl/ide_ctrl_signal_gen_if.sv
// Bundle between the register file / strobe detector / sector buffer and the signal
// generator, plus the pin-cell drive pairs it produces.
//   master : drives the control inputs, observes the pin drive values
//   slave  : the signal generator itself
interface ide_ctrl_signal_gen_if;

   logic cfg_nien;
   logic dev_selected;
   logic irq_set;
   logic irq_clr;
   logic status_rd;
   logic strobe;
   logic data_ready;
   logic dma_en;
   logic dma_avail;
   logic dma_xfer;
   logic intrq_out;
   logic intrq_oe;
   logic iordy_out;
   logic iordy_oe;
   logic dmarq_out;
   logic dmarq_oe;
   logic iordy_timeout;

   modport master (
      output cfg_nien, dev_selected, irq_set, irq_clr, status_rd, strobe, data_ready,
      output dma_en, dma_avail, dma_xfer,
      input  intrq_out, intrq_oe, iordy_out, iordy_oe, dmarq_out, dmarq_oe, iordy_timeout
   );

   modport slave (
      input  cfg_nien, dev_selected, irq_set, irq_clr, status_rd, strobe, data_ready,
      input  dma_en, dma_avail, dma_xfer,
      output intrq_out, intrq_oe, iordy_out, iordy_oe, dmarq_out, dmarq_oe, iordy_timeout
   );

endinterface

// File: rtl/ide_iordy_fsm.sv
// IORDY wait-state generator. A host strobe that the buffer cannot yet satisfy pulls
// IORDY low until data_ready or a timeout, then drives it high briefly before tristating.
//   clk, rst_n       : clock (rising edge), async active-low reset
//   strobe_i         : host DIOR-/DIOW- detected (pulse)
//   data_ready_i     : buffer can complete the access
//   iordy_out_o/oe_o : registered pin drive pair
//   iordy_timeout_o  : one-cycle pulse when the wait expired without data_ready
module ide_iordy_fsm import ide_ctrl_pkg::*; #(
   parameter int unsigned IORDY_TIMEOUT = IordyTimeoutDflt,
   parameter int unsigned IORDY_RELEASE = IordyReleaseDflt
) (
   input  logic clk,
   input  logic rst_n,
   input  logic strobe_i,
   input  logic data_ready_i,
   output logic iordy_out_o,
   output logic iordy_oe_o,
   output logic iordy_timeout_o
);

   localparam int unsigned WaitW = $clog2(IORDY_TIMEOUT + 1);
   localparam int unsigned RelW  = $clog2(IORDY_RELEASE + 1);

   iordy_state_e     state_q;
   logic [WaitW-1:0] wait_cnt_q;
   logic [RelW-1:0]  rel_cnt_q;
   logic             out_q, oe_q, tmo_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IordyIdle;
         wait_cnt_q <= '0;
         rel_cnt_q  <= '0;
         out_q      <= 1'b0;
         oe_q       <= 1'b0;
         tmo_q      <= 1'b0;
      end else begin
         tmo_q <= 1'b0;
         case (state_q)
            IordyIdle: begin
               // Strobes the buffer can satisfy immediately need no wait state.
               if (strobe_i && !data_ready_i) begin
                  state_q    <= IordyWait;
                  wait_cnt_q <= '0;
                  oe_q       <= 1'b1;
                  out_q      <= 1'b0;
               end
            end
            IordyWait: begin
               if (data_ready_i || (wait_cnt_q == WaitW'(IORDY_TIMEOUT - 1))) begin
                  state_q   <= IordyRelease;
                  rel_cnt_q <= '0;
                  out_q     <= 1'b1;
                  // data_ready on the final wait cycle is a normal completion.
                  tmo_q     <= !data_ready_i;
               end else if (wait_cnt_q < WaitW'(IORDY_TIMEOUT)) begin
                  wait_cnt_q <= wait_cnt_q + WaitW'(1);
               end
            end
            IordyRelease: begin
               if (rel_cnt_q >= RelW'(IORDY_RELEASE - 1)) begin
                  state_q <= IordyIdle;
                  oe_q    <= 1'b0;
                  out_q   <= 1'b0;
               end else begin
                  rel_cnt_q <= rel_cnt_q + RelW'(1);
               end
            end
            default: begin
               state_q <= IordyIdle;
               oe_q    <= 1'b0;
               out_q   <= 1'b0;
            end
         endcase
      end
   end

   assign iordy_out_o     = out_q;
   assign iordy_oe_o      = oe_q;
   assign iordy_timeout_o = tmo_q;

endmodule

// File: rtl/ide_ctrl_signal_gen.sv
// Drive value / output-enable generator for the device-side INTRQ, IORDY and DMARQ pins.
// All outputs are registered on the rising edge; the pin cells resample on the falling edge.
//   clk, rst_n : clock (rising edge), async active-low reset
//   bus        : slave side of ide_ctrl_signal_gen_if (control inputs, pin drive pairs,
//                iordy_timeout pulse)
module ide_ctrl_signal_gen import ide_ctrl_pkg::*; #(
   parameter int unsigned IORDY_TIMEOUT = IordyTimeoutDflt,
   parameter int unsigned IORDY_RELEASE = IordyReleaseDflt,
   parameter int unsigned DMA_BURST     = DmaBurstDflt,
   parameter int unsigned DMA_HOLDOFF   = DmaHoldoffDflt
) (
   input logic                  clk,
   input logic                  rst_n,
   ide_ctrl_signal_gen_if.slave bus
);

   localparam int unsigned BurstW = $clog2(DMA_BURST + 1);
   localparam int unsigned HoldW  = $clog2(DMA_HOLDOFF + 1);

   // INTRQ: set has priority over any clear arriving in the same cycle.
   logic intrq_q, intrq_oe_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         intrq_q    <= 1'b0;
         intrq_oe_q <= 1'b0;
      end else begin
         if (bus.irq_set) begin
            intrq_q <= 1'b1;
         end else if (bus.irq_clr || bus.status_rd) begin
            intrq_q <= 1'b0;
         end
         intrq_oe_q <= bus.dev_selected && !bus.cfg_nien;
      end
   end

   ide_iordy_fsm #(
      .IORDY_TIMEOUT (IORDY_TIMEOUT),
      .IORDY_RELEASE (IORDY_RELEASE)
   ) u_iordy (
      .clk             (clk),
      .rst_n           (rst_n),
      .strobe_i        (bus.strobe),
      .data_ready_i    (bus.data_ready),
      .iordy_out_o     (bus.iordy_out),
      .iordy_oe_o      (bus.iordy_oe),
      .iordy_timeout_o (bus.iordy_timeout)
   );

   // DMARQ
   dmarq_state_e      dq_state_q;
   logic [BurstW-1:0] burst_cnt_q, burst_nxt;
   logic [HoldW-1:0]  hold_cnt_q;
   logic              dmarq_q, dmarq_oe_q;

   always_comb begin
      burst_nxt = burst_cnt_q;
      if (bus.dma_xfer && (burst_cnt_q < BurstW'(DMA_BURST))) begin
         burst_nxt = burst_cnt_q + BurstW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dq_state_q  <= DmarqIdle;
         burst_cnt_q <= '0;
         hold_cnt_q  <= '0;
         dmarq_q     <= 1'b0;
         dmarq_oe_q  <= 1'b0;
      end else begin
         dmarq_oe_q <= bus.dma_en;
         if (!bus.dma_en) begin
            dq_state_q  <= DmarqIdle;
            burst_cnt_q <= '0;
            hold_cnt_q  <= '0;
            dmarq_q     <= 1'b0;
         end else begin
            case (dq_state_q)
               DmarqIdle: begin
                  if (bus.dma_avail) begin
                     dq_state_q  <= DmarqReq;
                     burst_cnt_q <= '0;
                     dmarq_q     <= 1'b1;
                  end
               end
               DmarqReq: begin
                  // A word moved in the same cycle the buffer runs dry still counts.
                  burst_cnt_q <= burst_nxt;
                  if ((burst_nxt == BurstW'(DMA_BURST)) || !bus.dma_avail) begin
                     dq_state_q <= DmarqHold;
                     hold_cnt_q <= '0;
                     dmarq_q    <= 1'b0;
                  end
               end
               DmarqHold: begin
                  // The IDLE decision is taken on the last holdoff edge so DMARQ stays low
                  // for exactly DMA_HOLDOFF cycles between back-to-back bursts.
                  if (hold_cnt_q >= HoldW'(DMA_HOLDOFF - 1)) begin
                     if (bus.dma_avail) begin
                        dq_state_q  <= DmarqReq;
                        burst_cnt_q <= '0;
                        dmarq_q     <= 1'b1;
                     end else begin
                        dq_state_q <= DmarqIdle;
                     end
                  end else begin
                     hold_cnt_q <= hold_cnt_q + HoldW'(1);
                  end
               end
               default: begin
                  dq_state_q <= DmarqIdle;
                  dmarq_q    <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.intrq_out = intrq_q;
   assign bus.intrq_oe  = intrq_oe_q;
   assign bus.dmarq_out = dmarq_q;
   assign bus.dmarq_oe  = dmarq_oe_q;

endmodule

// File: tb/tb_ide_ctrl_signal_gen.sv
// Bench for ide_ctrl_signal_gen: directed scenarios with hand-counted expectations, then
// randomized traffic, all compared every cycle against a behavioural model.
module tb_ide_ctrl_signal_gen;

   localparam int TIMEOUT = 1250;
   localparam int RELEASE = 2;
   localparam int BURST   = 16;
   localparam int HOLDOFF = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ide_ctrl_signal_gen_if bus ();

   ide_ctrl_signal_gen dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model: phases as small integers, elapsed time as plain counts.
   bit m_pending, m_intrq_oe, m_tmo, m_dma_oe;
   int m_io_ph, m_io_age;              // 0 idle, 1 waiting, 2 releasing
   int m_dq_ph, m_dq_words, m_dq_age;  // 0 idle, 1 requesting, 2 holding off

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: actual %0h required %0h", name, $time, act, exp);
      end
   endtask

   function automatic logic [6:0] act_vec();
      return {bus.intrq_out, bus.intrq_oe, bus.iordy_out, bus.iordy_oe,
              bus.dmarq_out, bus.dmarq_oe, bus.iordy_timeout};
   endfunction

   function automatic logic [6:0] exp_vec();
      return {m_pending, m_intrq_oe, m_io_ph == 2, m_io_ph != 0,
              m_dq_ph == 1, m_dma_oe, m_tmo};
   endfunction

   task automatic model_reset();
      m_pending = 0; m_intrq_oe = 0; m_tmo = 0; m_dma_oe = 0;
      m_io_ph = 0; m_io_age = 0;
      m_dq_ph = 0; m_dq_words = 0; m_dq_age = 0;
   endtask

   task automatic model_step();
      if (bus.irq_set) m_pending = 1;
      else if (bus.irq_clr || bus.status_rd) m_pending = 0;
      m_intrq_oe = bus.dev_selected && !bus.cfg_nien;

      m_tmo = 0;
      if (m_io_ph == 0) begin
         if (bus.strobe && !bus.data_ready) begin m_io_ph = 1; m_io_age = 0; end
      end else if (m_io_ph == 1) begin
         m_io_age++;
         if (bus.data_ready) begin m_io_ph = 2; m_io_age = 0; end
         else if (m_io_age == TIMEOUT) begin m_io_ph = 2; m_io_age = 0; m_tmo = 1; end
      end else begin
         m_io_age++;
         if (m_io_age == RELEASE) m_io_ph = 0;
      end

      m_dma_oe = bus.dma_en;
      if (!bus.dma_en) begin
         m_dq_ph = 0; m_dq_words = 0;
      end else if (m_dq_ph == 0) begin
         if (bus.dma_avail) begin m_dq_ph = 1; m_dq_words = 0; end
      end else if (m_dq_ph == 1) begin
         if (bus.dma_xfer) m_dq_words++;
         if (m_dq_words == BURST || !bus.dma_avail) begin m_dq_ph = 2; m_dq_age = 0; end
      end else begin
         m_dq_age++;
         if (m_dq_age == HOLDOFF) begin
            if (bus.dma_avail) begin m_dq_ph = 1; m_dq_words = 0; end
            else m_dq_ph = 0;
         end
      end
   endtask

   // Single compare process: advance the model on each edge, compare 1 time unit later.
   always begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_step();
      #1;
      if (rst_n) check("cycle outputs", act_vec(), exp_vec());
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_inputs();
      bus.cfg_nien = 0; bus.dev_selected = 0; bus.irq_set = 0; bus.irq_clr = 0;
      bus.status_rd = 0; bus.strobe = 0; bus.data_ready = 0; bus.dma_en = 0;
      bus.dma_avail = 0; bus.dma_xfer = 0;
   endtask

   initial begin
      int n;
      clear_inputs();
      model_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      check("reset outputs", act_vec(), 7'd0);
      rst_n = 1'b1;
      tick();

      // INTRQ
      bus.dev_selected = 1; bus.irq_set = 1;
      tick(); bus.irq_set = 0;
      check("intrq set out", bus.intrq_out, 1);
      check("intrq set oe", bus.intrq_oe, 1);
      bus.status_rd = 1;
      tick(); bus.status_rd = 0;
      check("intrq status_rd clears", bus.intrq_out, 0);
      bus.irq_set = 1; bus.status_rd = 1;
      tick(); bus.irq_set = 0; bus.status_rd = 0;
      check("intrq set beats clear", bus.intrq_out, 1);
      bus.cfg_nien = 1;
      tick();
      check("intrq nien oe", bus.intrq_oe, 0);
      check("intrq nien keeps pending", bus.intrq_out, 1);
      bus.cfg_nien = 0; bus.dev_selected = 0;
      tick();
      check("intrq deselected oe", bus.intrq_oe, 0);
      bus.dev_selected = 1;
      tick();
      check("intrq reenabled oe", bus.intrq_oe, 1);
      check("intrq reenabled out", bus.intrq_out, 1);
      bus.irq_clr = 1;
      tick(); bus.irq_clr = 0;
      check("intrq irq_clr", bus.intrq_out, 0);

      // IORDY: data_ready arrives 10 cycles after the strobe
      bus.strobe = 1;
      tick(); bus.strobe = 0;
      check("iordy wait oe", bus.iordy_oe, 1);
      check("iordy wait out", bus.iordy_out, 0);
      repeat (9) tick();
      check("iordy still waiting", bus.iordy_oe, 1);
      bus.data_ready = 1;
      tick(); bus.data_ready = 0;
      check("iordy release 1", bus.iordy_out, 1);
      tick();
      check("iordy release 2", bus.iordy_out, 1);
      tick();
      check("iordy tristated", bus.iordy_oe, 0);
      bus.strobe = 1; bus.data_ready = 1;
      tick(); bus.strobe = 0; bus.data_ready = 0;
      check("iordy ready strobe no oe", bus.iordy_oe, 0);
      tick();
      check("iordy ready strobe no oe 2", bus.iordy_oe, 0);

      // IORDY timeout
      bus.strobe = 1;
      tick(); bus.strobe = 0;
      n = 0;
      while (!bus.iordy_timeout && n < 2000) begin tick(); n++; end
      check("iordy timeout latency", n, TIMEOUT);
      check("iordy out at timeout", bus.iordy_out, 1);
      tick();
      check("iordy timeout single pulse", bus.iordy_timeout, 0);
      check("iordy release after timeout", bus.iordy_out, 1);
      tick();
      check("iordy idle after timeout", bus.iordy_oe, 0);

      // DMARQ full burst
      bus.dma_en = 1; bus.dma_avail = 1;
      tick();
      check("dmarq req out", bus.dmarq_out, 1);
      check("dmarq oe", bus.dmarq_oe, 1);
      for (int i = 0; i < BURST; i++) begin
         check("dmarq high during burst", bus.dmarq_out, 1);
         bus.dma_xfer = 1;
         tick();
      end
      bus.dma_xfer = 0;
      check("dmarq low after burst", bus.dmarq_out, 0);
      n = 0;
      while (bus.dmarq_out == 0 && n < 20) begin tick(); n++; end
      check("dmarq holdoff cycles", n, HOLDOFF);

      // DMARQ early hold on dma_avail drop
      for (int i = 0; i < 5; i++) begin bus.dma_xfer = 1; tick(); end
      bus.dma_xfer = 0; bus.dma_avail = 0;
      tick();
      check("dmarq early hold", bus.dmarq_out, 0);
      repeat (8) tick();
      check("dmarq idle without avail", bus.dmarq_out, 0);
      bus.dma_avail = 1;
      tick();
      check("dmarq rerequest", bus.dmarq_out, 1);
      bus.dma_en = 0;
      tick();
      check("dmarq disabled oe", bus.dmarq_oe, 0);
      check("dmarq disabled out", bus.dmarq_out, 0);

      // Asynchronous reset in the middle of an IORDY wait
      bus.irq_set = 1; bus.dma_en = 1; bus.dma_avail = 1; bus.strobe = 1;
      tick();
      clear_inputs();
      bus.dma_en = 1; bus.dma_avail = 1;
      tick();
      #1 rst_n = 1'b0;
      #1 check("async reset mid-wait", act_vec(), 7'd0);
      clear_inputs();
      tick(); tick();
      rst_n = 1'b1;
      tick(); tick();
      check("no wait after reset", bus.iordy_oe, 0);
      bus.strobe = 1;
      tick(); bus.strobe = 0;
      check("new strobe reenters wait", bus.iordy_oe, 1);
      bus.data_ready = 1;
      tick(); bus.data_ready = 0;

      // Randomized traffic
      bus.dev_selected = 1; bus.dma_en = 1;
      for (int c = 0; c < 4000; c++) begin
         bus.strobe     = ($urandom_range(0, 15) == 0);
         bus.data_ready = ($urandom_range(0, 9) == 0);
         bus.irq_set    = ($urandom_range(0, 19) == 0);
         bus.irq_clr    = ($urandom_range(0, 49) == 0);
         bus.status_rd  = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 49) == 0) bus.cfg_nien = ~bus.cfg_nien;
         if ($urandom_range(0, 49) == 0) bus.dev_selected = ~bus.dev_selected;
         if ($urandom_range(0, 199) == 0) bus.dma_en = ~bus.dma_en;
         bus.dma_avail  = ($urandom_range(0, 9) != 0);
         bus.dma_xfer   = ($urandom_range(0, 1) == 1);
         tick();
      end

      clear_inputs();
      tick(); tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
